// File: rtl/vector_seq_alu.sv
// Multi-cycle vector execution unit: processes LANES elements per cycle
// across a VECTOR_SIZE-element vector, with reduction-sum and scalar-broadcast
// modes. Completed results and NZVC flags are held until the next completion.
module vector_seq_alu #(
  parameter int DATA_WIDTH  = 19,
  parameter int VECTOR_SIZE = 6,
  parameter int LANES       = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              flush,
  input  logic [2:0]                        aluControl,
  input  logic                              broadcast,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] operand1,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] operand2,
  output logic                              busy,
  output logic                              done,
  output logic [VECTOR_SIZE*DATA_WIDTH-1:0] result,
  output logic                              N,
  output logic                              Z,
  output logic                              V,
  output logic                              C
);

  localparam int VW     = VECTOR_SIZE * DATA_WIDTH;
  localparam int CHUNKS = (VECTOR_SIZE + LANES - 1) / LANES;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [DATA_WIDTH-1:0] DW_MOD  = DATA_WIDTH'(DATA_WIDTH);
  localparam logic [CW-1:0]         LAST_CH = CW'(CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           chunk_q;
  logic                    load, step, last, finish;

  logic [VW-1:0]           op1_p0, op2_p0;
  logic [2:0]              ctl_p0;
  logic [VW-1:0]           work_q, work_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic                    red_c, red_v;
  logic                    c_d, v_d;
  logic [VW-1:0]           res_d;

  // Per-element operation; reduction (111) does not use the working buffer.
  function automatic logic [DATA_WIDTH-1:0] alu_elem(
    input logic [2:0]            ctl,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH-1:0] amt;
    amt = b % DW_MOD;
    case (ctl)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return a << amt;
      3'b110:  return a >> amt;
      default: return '0;
    endcase
  endfunction

  // Two's-complement overflow of a+b=s: same-sign operands, result sign differs.
  function automatic logic add_ovf(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b,
    input logic signed [DATA_WIDTH-1:0] s
  );
    return (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
  endfunction

  // Two's-complement overflow of a-b=d: opposite-sign operands, result sign flips.
  function automatic logic sub_ovf(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b,
    input logic signed [DATA_WIDTH-1:0] d
  );
    return (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) && (d[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
  endfunction

  assign last = (chunk_q == LAST_CH);
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and sequencing controls; flush outranks start and chunk work.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush)      state_d = IDLE;
        else if (start) begin load = 1'b1; state_d = RUN; end
      end
      RUN: begin
        if (flush) state_d = IDLE;
        else begin
          step = 1'b1;
          if (last) begin finish = 1'b1; state_d = DONE; end
        end
      end
      DONE: begin
        if (flush)      state_d = IDLE;
        else if (start) begin load = 1'b1; state_d = RUN; end
        else            state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Chunk counter: restarts on accept, completion or abort.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                   chunk_q <= '0;
    else if (load || finish || (flush && busy))  chunk_q <= '0;
    else if (step)                               chunk_q <= chunk_q + 1'b1;
  end

  // Operand latch (broadcast applied here) and working storage.
  always_ff @(posedge clock) begin
    if (load) begin
      op1_p0 <= operand1;
      op2_p0 <= broadcast ? {VECTOR_SIZE{operand2[DATA_WIDTH-1:0]}} : operand2;
      ctl_p0 <= aluControl;
      work_q <= '0;
      acc_q  <= '0;
    end else if (step) begin
      work_q <= work_d;
      acc_q  <= acc_d;
    end
  end

  // Current chunk: element results and serial accumulation for reduction.
  always_comb begin
    logic [DATA_WIDTH-1:0] a, b;
    logic [DATA_WIDTH:0]   sum;
    work_d = work_q;
    acc_d  = acc_q;
    red_c  = 1'b0;
    red_v  = 1'b0;
    a      = '0;
    b      = '0;
    sum    = '0;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      if ((i / LANES) == int'(chunk_q)) begin
        a = op1_p0[i*DATA_WIDTH +: DATA_WIDTH];
        b = op2_p0[i*DATA_WIDTH +: DATA_WIDTH];
        work_d[i*DATA_WIDTH +: DATA_WIDTH] = alu_elem(ctl_p0, a, b);
        sum   = {1'b0, acc_d} + {1'b0, a};
        red_c = sum[DATA_WIDTH];
        red_v = add_ovf(acc_d, a, sum[DATA_WIDTH-1:0]);
        acc_d = sum[DATA_WIDTH-1:0];
      end
    end
  end

  // Completion value and carry/overflow of element 0.
  always_comb begin
    logic [DATA_WIDTH-1:0] a0, b0;
    logic [DATA_WIDTH:0]   sum0, dif0;
    a0    = op1_p0[DATA_WIDTH-1:0];
    b0    = op2_p0[DATA_WIDTH-1:0];
    sum0  = {1'b0, a0} + {1'b0, b0};
    dif0  = {1'b0, a0} - {1'b0, b0};
    res_d = (ctl_p0 == 3'b111) ? VW'(acc_d) : work_d;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (ctl_p0)
      3'b000: begin c_d = sum0[DATA_WIDTH];  v_d = add_ovf(a0, b0, sum0[DATA_WIDTH-1:0]); end
      3'b001: begin c_d = ~dif0[DATA_WIDTH]; v_d = sub_ovf(a0, b0, dif0[DATA_WIDTH-1:0]); end
      3'b111: begin c_d = red_c;             v_d = red_v; end
      default: begin c_d = 1'b0; v_d = 1'b0; end
    endcase
  end

  // Architectural result and flags, updated only on completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result <= '0;
      N      <= 1'b0;
      Z      <= 1'b0;
      V      <= 1'b0;
      C      <= 1'b0;
    end else if (finish) begin
      result <= res_d;
      N      <= res_d[DATA_WIDTH-1];
      Z      <= (res_d[DATA_WIDTH-1:0] == '0);
      V      <= v_d;
      C      <= c_d;
    end
  end

endmodule

// File: tb/tb_vector_seq_alu.sv
// Directed bench for vector_seq_alu: default instance (LANES=2) plus a
// LANES=4 instance sharing the same inputs for the reduction timing case.
module tb_vector_seq_alu;

  localparam int DW = 19;
  localparam int VS = 6;
  localparam int VW = DW * VS;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic [2:0]    aluControl = 3'b000;
  logic          broadcast = 1'b0;
  logic [VW-1:0] operand1 = '0;
  logic [VW-1:0] operand2 = '0;

  logic          busy, done, N, Z, V, C;
  logic [VW-1:0] result;
  logic          busy4, done4, N4, Z4, V4, C4;
  logic [VW-1:0] result4;

  int tests = 0;
  int fails = 0;

  vector_seq_alu #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .LANES(2)) dut (
    .clock(clock), .reset(reset), .start(start), .flush(flush),
    .aluControl(aluControl), .broadcast(broadcast),
    .operand1(operand1), .operand2(operand2),
    .busy(busy), .done(done), .result(result),
    .N(N), .Z(Z), .V(V), .C(C)
  );

  vector_seq_alu #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .LANES(4)) dut4 (
    .clock(clock), .reset(reset), .start(start), .flush(flush),
    .aluControl(aluControl), .broadcast(broadcast),
    .operand1(operand1), .operand2(operand2),
    .busy(busy4), .done(done4), .result(result4),
    .N(N4), .Z(Z4), .V(V4), .C(C4)
  );

  always #5 clock = ~clock;

  function automatic logic [VW-1:0] vec6(input int e0, e1, e2, e3, e4, e5);
    logic [VW-1:0] v;
    v = '0;
    v[0*DW +: DW] = DW'(e0);
    v[1*DW +: DW] = DW'(e1);
    v[2*DW +: DW] = DW'(e2);
    v[3*DW +: DW] = DW'(e3);
    v[4*DW +: DW] = DW'(e4);
    v[5*DW +: DW] = DW'(e5);
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch an op: drive inputs, one start edge, then scramble inputs.
  task automatic start_op(input logic [2:0] ctl, input logic bc,
                          input logic [VW-1:0] o1, input logic [VW-1:0] o2);
    aluControl = ctl;
    broadcast  = bc;
    operand1   = o1;
    operand2   = o2;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    aluControl = ~ctl;
    broadcast  = ~bc;
    operand1   = ~o1;
    operand2   = ~o2;
  endtask

  // Count edges until done (bounded), then compare with the expected latency.
  task automatic wait_done(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, VW'(n), VW'(exp_cycles));
  endtask

  initial begin
    // Reset state
    tick();
    check("reset_busy", VW'(busy), '0);
    check("reset_done", VW'(done), '0);
    check("reset_result", result, '0);
    check("reset_flags", VW'({N, Z, V, C}), '0);
    reset = 1'b0;
    tick();

    // Vector add with latency and operand-latch check
    start_op(3'b000, 1'b0, vec6(1, 2, 3, 4, 5, 6), vec6(10, 10, 10, 10, 10, 10));
    check("add_busy_e0", VW'(busy), VW'(1));
    tick();
    tick();
    check("lanes4_done_e2", VW'(done4), VW'(1));
    check("add_not_done_e2", VW'(done), '0);
    tick();
    check("add_done_e3", VW'(done), VW'(1));
    check("add_busy_low", VW'(busy), '0);
    check("add_result", result, vec6(11, 12, 13, 14, 15, 16));
    check("add_flags", VW'({N, Z, V, C}), VW'(4'b0000));
    tick();
    check("done_pulse_drop", VW'(done), '0);
    check("result_held", result, vec6(11, 12, 13, 14, 15, 16));

    // Signed overflow, then carry out with zero result
    start_op(3'b000, 1'b0, vec6(262143, 0, 0, 0, 0, 0), vec6(1, 0, 0, 0, 0, 0));
    wait_done("ovf1_lat", 3);
    check("ovf1_result", result, vec6(262144, 0, 0, 0, 0, 0));
    check("ovf1_flags", VW'({N, Z, V, C}), VW'(4'b1010));
    tick();
    start_op(3'b000, 1'b0, vec6(524287, 0, 0, 0, 0, 0), vec6(1, 0, 0, 0, 0, 0));
    wait_done("ovf2_lat", 3);
    check("ovf2_result", result, '0);
    check("ovf2_flags", VW'({N, Z, V, C}), VW'(4'b0101));
    tick();

    // Subtract with borrow
    start_op(3'b001, 1'b0, vec6(3, 10, 0, 7, 100, 1), vec6(5, 4, 0, 7, 1, 2));
    wait_done("sub_lat", 3);
    check("sub_result", result, vec6(524286, 6, 0, 0, 99, 524287));
    check("sub_flags", VW'({N, Z, V, C}), VW'(4'b1000));
    tick();

    // XOR to zero: logical op clears C and V
    start_op(3'b100, 1'b0, vec6(5, 6, 7, 8, 9, 10), vec6(5, 6, 7, 8, 9, 10));
    wait_done("xor_lat", 3);
    check("xor_result", result, '0);
    check("xor_flags", VW'({N, Z, V, C}), VW'(4'b0100));
    tick();

    // Per-element logical shift right, amount 20 wraps to 1
    start_op(3'b110, 1'b0, vec6(256, 256, 256, 256, 256, 256), vec6(1, 2, 3, 4, 8, 20));
    wait_done("shr_lat", 3);
    check("shr_result", result, vec6(128, 64, 32, 16, 1, 128));
    tick();

    // Broadcast shift left by 2, then by 21 (mod 19 = 2)
    start_op(3'b101, 1'b1, vec6(3, 3, 3, 3, 3, 3), vec6(2, 7, 7, 7, 7, 7));
    wait_done("bc_lat", 3);
    check("bc_shl2_result", result, vec6(12, 12, 12, 12, 12, 12));
    check("bc_shl2_flags", VW'({N, Z, V, C}), VW'(4'b0000));
    tick();
    start_op(3'b101, 1'b1, vec6(3, 3, 3, 3, 3, 3), vec6(21, 5, 5, 5, 5, 5));
    wait_done("bc21_lat", 3);
    check("bc_shl21_result", result, vec6(12, 12, 12, 12, 12, 12));
    tick();

    // Reduction on both lane configurations
    start_op(3'b111, 1'b0, vec6(100, 200, 300, 400, 500, 600), vec6(9, 9, 9, 9, 9, 9));
    tick();
    tick();
    check("red4_done_e2", VW'(done4), VW'(1));
    check("red4_result", result4, vec6(2100, 0, 0, 0, 0, 0));
    check("red2_not_done_e2", VW'(done), '0);
    tick();
    check("red2_done_e3", VW'(done), VW'(1));
    check("red2_result", result, vec6(2100, 0, 0, 0, 0, 0));
    check("red2_flags", VW'({N, Z, V, C}), VW'(4'b0000));
    tick();

    // Start while busy is ignored
    start_op(3'b000, 1'b0, vec6(1, 1, 1, 1, 1, 1), vec6(2, 2, 2, 2, 2, 2));
    aluControl = 3'b001;
    operand1   = vec6(40, 40, 40, 40, 40, 40);
    operand2   = vec6(1, 1, 1, 1, 1, 1);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    wait_done("ign_start_lat", 2);
    check("ign_start_result", result, vec6(3, 3, 3, 3, 3, 3));
    tick();

    // Flush in RUN chunk 1: no done, result held
    start_op(3'b000, 1'b0, vec6(50, 50, 50, 50, 50, 50), vec6(50, 50, 50, 50, 50, 50));
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", VW'(busy), '0);
    check("flush_done", VW'(done), '0);
    check("flush_result", result, vec6(3, 3, 3, 3, 3, 3));
    check("flush_flags", VW'({N, Z, V, C}), VW'(4'b0000));
    for (int k = 0; k < 3; k++) begin
      tick();
      check("flush_no_done", VW'(done), '0);
    end

    // Flush together with start in IDLE: no operation
    flush = 1'b1;
    start = 1'b1;
    tick();
    flush = 1'b0;
    start = 1'b0;
    check("flush_start_idle", VW'(busy), '0);
    tick();

    // Back-to-back: start held through DONE restarts on the same edge
    aluControl = 3'b000;
    broadcast  = 1'b0;
    operand1   = vec6(1, 1, 1, 1, 1, 1);
    operand2   = vec6(1, 1, 1, 1, 1, 1);
    start      = 1'b1;
    tick();
    wait_done("b2b_first_lat", 3);
    check("b2b_first_result", result, vec6(2, 2, 2, 2, 2, 2));
    operand1 = vec6(4, 4, 4, 4, 4, 4);
    operand2 = vec6(4, 4, 4, 4, 4, 4);
    tick();
    start = 1'b0;
    check("b2b_restart_busy", VW'(busy), VW'(1));
    check("b2b_restart_done", VW'(done), '0);
    wait_done("b2b_second_lat", 3);
    check("b2b_second_result", result, vec6(8, 8, 8, 8, 8, 8));
    tick();

    // Reset mid-operation, then a clean operation
    start_op(3'b000, 1'b0, vec6(9, 9, 9, 9, 9, 9), vec6(9, 9, 9, 9, 9, 9));
    tick();
    check("pre_reset_busy", VW'(busy), VW'(1));
    #2 reset = 1'b1;
    #1;
    check("midreset_busy", VW'(busy), '0);
    check("midreset_done", VW'(done), '0);
    check("midreset_result", result, '0);
    check("midreset_flags", VW'({N, Z, V, C}), '0);
    #2 reset = 1'b0;
    tick();
    check("postreset_idle", VW'(busy), '0);
    start_op(3'b000, 1'b0, vec6(1, 2, 3, 4, 5, 6), vec6(6, 5, 4, 3, 2, 1));
    wait_done("postreset_lat", 3);
    check("postreset_result", result, vec6(7, 7, 7, 7, 7, 7));
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
